tft_bus_sink: RTL and testbench

Receive-side model of the 16-bit 8080-style parallel TFT bus (WR/RS/RD/RESET/data) driven by the panel writer. It decodes the ILI9341 command subset used by the writer (sleep out, display on, MADCTL, CASET, PASET, RAMWR/RAMWRC) and emits one (x, y, rgb565) pixel strobe per GRAM data write. It sits in place of the physical panel: for loopback verification of the writer, and as the front end of an on-chip framebuffer or scaler. It runs in the writer's clock domain.

---
 rtl/tft_bus_pkg.sv | 29 ++
 rtl/tft_bus_sampler.sv | 75 +++++++
 rtl/tft_bus_sink.sv | 222 ++++++++++++++++++++++
 tb/tb_tft_bus_sink.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_bus_pkg.sv
// Shared constants and types for the TFT bus sink: ILI9341 command codes
// understood by the decoder and the decoder state encoding.
package tft_bus_pkg;

  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKIP  = 3'd1,
    MAD   = 3'd2,
    CASET = 3'd3,
    PASET = 3'd4,
    GRAM  = 3'd5
  } dec_state_t;

  // Coordinates arrive as a big-endian byte pair; only 9 bits are kept.
  function automatic logic [8:0] join_coord(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[0], lo};
  endfunction

endpackage

// File: rtl/tft_bus_sampler.sv
// Front end of the TFT bus sink: registers the asynchronous-looking panel bus
// into the clk domain, detects WR rising edges and flags WR/RD collisions.
module tft_bus_sampler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_n,
  input  logic        rs,
  input  logic        rd_n,
  input  logic        bus_reset_n,
  input  logic [15:0] data,
  output logic        evt,
  output logic        evt_rs,
  output logic [15:0] evt_data,
  output logic        reset_n,
  output logic        protocol_err
);

  logic        s_wr;
  logic        s_rs;
  logic        s_rd;
  logic        s_reset;
  logic [15:0] s_data;
  logic        s_wr_d;
  logic        s_rs_d;
  logic [15:0] s_data_d;

  // Sample every bus line and keep one older copy; WR/RD idle high so a bus
  // that is already idle at release never looks like a rising WR edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_wr     <= 1'b1;
      s_rs     <= 1'b0;
      s_rd     <= 1'b1;
      s_reset  <= 1'b0;
      s_data   <= '0;
      s_wr_d   <= 1'b1;
      s_rs_d   <= 1'b0;
      s_data_d <= '0;
    end else begin
      s_wr     <= wr_n;
      s_rs     <= rs;
      s_rd     <= rd_n;
      s_reset  <= bus_reset_n;
      s_data   <= data;
      s_wr_d   <= s_wr;
      s_rs_d   <= s_rs;
      s_data_d <= s_data;
    end
  end

  // Register the write event together with the RS/data captured while WR was low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt      <= 1'b0;
      evt_rs   <= 1'b0;
      evt_data <= '0;
      reset_n  <= 1'b0;
    end else begin
      evt      <= s_wr & ~s_wr_d & s_reset;
      evt_rs   <= s_rs_d;
      evt_data <= s_data_d;
      reset_n  <= s_reset;
    end
  end

  // Sticky collision flag; the panel reset line deliberately does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else if (!s_wr && !s_rd) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: rtl/tft_bus_sink.sv
// Receive-side model of the 8080-style TFT bus: decodes the ILI9341 command
// subset and turns each GRAM data write into an (x, y, rgb565) pixel strobe.
module tft_bus_sink
  import tft_bus_pkg::*;
#(
  parameter int SCR_W = 320,
  parameter int SCR_H = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        screenWR,
  input  logic        screenRS,
  input  logic        screenRD,
  input  logic        screenRESET,
  input  logic [15:0] screenData,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        sleep_out,
  output logic        display_on,
  output logic [7:0]  madctl,
  output logic        protocol_err
);

  localparam logic [8:0] XE_RST = 9'(SCR_W - 1);
  localparam logic [8:0] YE_RST = 9'(SCR_H - 1);

  logic        evt;
  logic        evt_rs;
  logic [15:0] evt_data;
  logic        bus_reset_n;

  tft_bus_sampler u_sampler (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_n         (screenWR),
    .rs           (screenRS),
    .rd_n         (screenRD),
    .bus_reset_n  (screenRESET),
    .data         (screenData),
    .evt          (evt),
    .evt_rs       (evt_rs),
    .evt_data     (evt_data),
    .reset_n      (bus_reset_n),
    .protocol_err (protocol_err)
  );

  dec_state_t  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  pb0_q, pb0_d;
  logic [7:0]  pb1_q, pb1_d;
  logic [7:0]  pb2_q, pb2_d;
  logic [8:0]  xs_q, xs_d, xe_q, xe_d;
  logic [8:0]  ys_q, ys_d, ye_q, ye_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic        pix_valid_d;
  logic [8:0]  pix_x_d, pix_y_d;
  logic [15:0] pix_data_d;
  logic        sleep_d, disp_d;
  logic [7:0]  madctl_d;
  logic [7:0]  cmd_byte;

  assign cmd_byte = evt_data[7:0];

  // Decode one bus event per cycle; a low panel reset line overrides everything.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pb0_d       = pb0_q;
    pb1_d       = pb1_q;
    pb2_d       = pb2_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x;
    pix_y_d     = pix_y;
    pix_data_d  = pix_data;
    sleep_d     = sleep_out;
    disp_d      = display_on;
    madctl_d    = madctl;

    if (evt) begin
      if (!evt_rs) begin
        idx_d = 2'd0;
        unique case (cmd_byte)
          CMD_SLPOUT:  begin sleep_d = 1'b1; state_d = IDLE; end
          CMD_SLPIN:   begin sleep_d = 1'b0; state_d = IDLE; end
          CMD_DISPON:  begin disp_d  = 1'b1; state_d = IDLE; end
          CMD_DISPOFF: begin disp_d  = 1'b0; state_d = IDLE; end
          CMD_MADCTL:  state_d = MAD;
          CMD_CASET:   state_d = CASET;
          CMD_PASET:   state_d = PASET;
          CMD_RAMWR:   begin x_d = xs_q; y_d = ys_q; state_d = GRAM; end
          CMD_RAMWRC:  state_d = GRAM;
          default:     state_d = SKIP;
        endcase
      end else begin
        unique case (state_q)
          MAD: begin
            madctl_d = cmd_byte;
            state_d  = SKIP;
          end
          CASET, PASET: begin
            idx_d = 2'(idx_q + 2'd1);
            unique case (idx_q)
              2'd0: pb0_d = cmd_byte;
              2'd1: pb1_d = cmd_byte;
              2'd2: pb2_d = cmd_byte;
              default: begin
                if (state_q == CASET) begin
                  xs_d = join_coord(pb0_q, pb1_q);
                  xe_d = join_coord(pb2_q, cmd_byte);
                end else begin
                  ys_d = join_coord(pb0_q, pb1_q);
                  ye_d = join_coord(pb2_q, cmd_byte);
                end
                state_d = SKIP;
              end
            endcase
          end
          GRAM: begin
            pix_valid_d = 1'b1;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_data_d  = evt_data;
            if (x_q == xe_q) begin
              x_d = xs_q;
              y_d = (y_q == ye_q) ? ys_q : 9'(y_q + 9'd1);
            end else begin
              x_d = 9'(x_q + 9'd1);
            end
          end
          default: ;
        endcase
      end
    end

    if (!bus_reset_n) begin
      state_d     = IDLE;
      idx_d       = 2'd0;
      pb0_d       = '0;
      pb1_d       = '0;
      pb2_d       = '0;
      xs_d        = '0;
      xe_d        = XE_RST;
      ys_d        = '0;
      ye_d        = YE_RST;
      x_d         = '0;
      y_d         = '0;
      pix_valid_d = 1'b0;
      pix_x_d     = '0;
      pix_y_d     = '0;
      pix_data_d  = '0;
      sleep_d     = 1'b0;
      disp_d      = 1'b0;
      madctl_d    = '0;
    end
  end

  // Decoder state and parameter byte collection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      pb0_q   <= '0;
      pb1_q   <= '0;
      pb2_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pb0_q   <= pb0_d;
      pb1_q   <= pb1_d;
      pb2_q   <= pb2_d;
    end
  end

  // Address window and the running GRAM write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q <= '0;
      xe_q <= XE_RST;
      ys_q <= '0;
      ye_q <= YE_RST;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      xs_q <= xs_d;
      xe_q <= xe_d;
      ys_q <= ys_d;
      ye_q <= ye_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  // Registered outputs: pixel strobe and panel status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      sleep_out  <= 1'b0;
      display_on <= 1'b0;
      madctl     <= '0;
    end else begin
      pix_valid  <= pix_valid_d;
      pix_x      <= pix_x_d;
      pix_y      <= pix_y_d;
      pix_data   <= pix_data_d;
      sleep_out  <= sleep_d;
      display_on <= disp_d;
      madctl     <= madctl_d;
    end
  end

endmodule

// File: tb/tb_tft_bus_sink.sv
// Directed bench for tft_bus_sink: drives bus writes at the fastest legal
// rate and compares captured pixel strobes and flags with hand-worked values.
module tb_tft_bus_sink;

  logic        clk;
  logic        rst_n;
  logic        screenWR;
  logic        screenRS;
  logic        screenRD;
  logic        screenRESET;
  logic [15:0] screenData;
  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic        sleep_out;
  logic        display_on;
  logic [7:0]  madctl;
  logic        protocol_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int cap_n = 0;
  int base;
  logic [8:0]  cap_x   [0:1023];
  logic [8:0]  cap_y   [0:1023];
  logic [15:0] cap_d   [0:1023];
  int          cap_cyc [0:1023];

  int ex_x [0:6] = '{10, 11, 12, 10, 11, 12, 10};
  int ex_y [0:6] = '{5, 5, 5, 6, 6, 6, 5};

  tft_bus_sink #(.SCR_W(320), .SCR_H(240)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .screenWR     (screenWR),
    .screenRS     (screenRS),
    .screenRD     (screenRD),
    .screenRESET  (screenRESET),
    .screenData   (screenData),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .sleep_out    (sleep_out),
    .display_on   (display_on),
    .madctl       (madctl),
    .protocol_err (protocol_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure pixel spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every pixel strobe away from the active edge
  always @(negedge clk) begin
    if (pix_valid && cap_n < 1024) begin
      cap_x[cap_n]   = pix_x;
      cap_y[cap_n]   = pix_y;
      cap_d[cap_n]   = pix_data;
      cap_cyc[cap_n] = cyc;
      cap_n          = cap_n + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus write: WR low for one cycle, high for one cycle (called at a negedge)
  task automatic applyStimulus(input logic rs, input logic [15:0] data);
    screenRS   = rs;
    screenData = data;
    screenWR   = 1'b0;
    @(negedge clk);
    screenWR   = 1'b1;
    @(negedge clk);
  endtask

  task automatic sendCmd(input logic [7:0] c);
    applyStimulus(1'b0, {8'h00, c});
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_cnt++;
    assert (observed === expected) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    screenWR    = 1'b1;
    screenRS    = 1'b1;
    screenRD    = 1'b1;
    screenRESET = 1'b1;
    screenData  = '0;
    idle(3);
    rst_n = 1'b1;
    idle(4);

    $display("[TB] reset state");
    checkOutput("rst_pix_valid",    32'(pix_valid),    0);
    checkOutput("rst_pix_x",        32'(pix_x),        0);
    checkOutput("rst_pix_y",        32'(pix_y),        0);
    checkOutput("rst_pix_data",     32'(pix_data),     0);
    checkOutput("rst_sleep_out",    32'(sleep_out),    0);
    checkOutput("rst_display_on",   32'(display_on),   0);
    checkOutput("rst_madctl",       32'(madctl),       0);
    checkOutput("rst_protocol_err", 32'(protocol_err), 0);

    $display("[TB] full-screen row wrap");
    base = cap_n;
    sendCmd(8'h2C);
    applyStimulus(1'b1, 16'hA5A5);
    idle(4);
    checkOutput("row_first_count", 32'(cap_n - base), 1);
    checkOutput("row_first_x",     32'(cap_x[base]), 0);
    checkOutput("row_first_y",     32'(cap_y[base]), 0);
    checkOutput("row_first_data",  32'(cap_d[base]), 'hA5A5);
    for (int i = 1; i <= 320; i++) applyStimulus(1'b1, 16'(i));
    idle(4);
    checkOutput("row_count",     32'(cap_n - base), 321);
    checkOutput("row_end_x",     32'(cap_x[base + 319]), 319);
    checkOutput("row_end_y",     32'(cap_y[base + 319]), 0);
    checkOutput("row_next_x",    32'(cap_x[base + 320]), 0);
    checkOutput("row_next_y",    32'(cap_y[base + 320]), 1);
    checkOutput("row_next_data", 32'(cap_d[base + 320]), 320);

    $display("[TB] status flags");
    sendCmd(8'h11);
    sendCmd(8'h29);
    sendCmd(8'h36);
    applyStimulus(1'b1, 16'h0060);
    idle(4);
    checkOutput("flag_sleep_out",  32'(sleep_out),  1);
    checkOutput("flag_display_on", 32'(display_on), 1);
    checkOutput("flag_madctl",     32'(madctl),     'h60);
    sendCmd(8'h28);
    idle(4);
    checkOutput("dispoff_display_on", 32'(display_on), 0);
    checkOutput("dispoff_sleep_out",  32'(sleep_out),  1);

    $display("[TB] 3x2 window");
    base = cap_n;
    sendCmd(8'h2A);
    applyStimulus(1'b1, 16'h0000);
    applyStimulus(1'b1, 16'h000A);
    applyStimulus(1'b1, 16'h0000);
    applyStimulus(1'b1, 16'h000C);
    sendCmd(8'h2B);
    applyStimulus(1'b1, 16'h0000);
    applyStimulus(1'b1, 16'h0005);
    applyStimulus(1'b1, 16'h0000);
    applyStimulus(1'b1, 16'h0006);
    sendCmd(8'h2C);
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 16'(i));
    idle(4);
    checkOutput("win_count", 32'(cap_n - base), 7);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("win_x%0d", i), 32'(cap_x[base + i]), 32'(ex_x[i]));
      checkOutput($sformatf("win_y%0d", i), 32'(cap_y[base + i]), 32'(ex_y[i]));
      checkOutput($sformatf("win_d%0d", i), 32'(cap_d[base + i]), 32'(i + 1));
      if (i > 0)
        checkOutput($sformatf("win_gap%0d", i), 32'(cap_cyc[base + i] - cap_cyc[base + i - 1]), 2);
    end

    $display("[TB] command abort and RAMWRC");
    base = cap_n;
    sendCmd(8'h2C);
    applyStimulus(1'b1, 16'h0101);
    applyStimulus(1'b1, 16'h0102);
    sendCmd(8'h00);
    applyStimulus(1'b1, 16'h0103);
    idle(4);
    checkOutput("abort_count", 32'(cap_n - base), 2);
    sendCmd(8'h3C);
    applyStimulus(1'b1, 16'h0104);
    idle(4);
    checkOutput("ramwrc_count", 32'(cap_n - base), 3);
    checkOutput("ramwrc_x",     32'(cap_x[base + 2]), 12);
    checkOutput("ramwrc_y",     32'(cap_y[base + 2]), 5);
    checkOutput("ramwrc_data",  32'(cap_d[base + 2]), 'h0104);

    $display("[TB] panel reset mid-CASET");
    sendCmd(8'h2A);
    applyStimulus(1'b1, 16'h0000);
    applyStimulus(1'b1, 16'h0005);
    screenRESET = 1'b0;
    idle(3);
    screenRESET = 1'b1;
    idle(4);
    checkOutput("hwrst_sleep_out",  32'(sleep_out),  0);
    checkOutput("hwrst_display_on", 32'(display_on), 0);
    checkOutput("hwrst_madctl",     32'(madctl),     0);
    base = cap_n;
    sendCmd(8'h2C);
    applyStimulus(1'b1, 16'hBEEF);
    for (int i = 1; i <= 320; i++) applyStimulus(1'b1, 16'(i));
    idle(4);
    checkOutput("hwrst_count",   32'(cap_n - base), 321);
    checkOutput("hwrst_first_x", 32'(cap_x[base]), 0);
    checkOutput("hwrst_first_y", 32'(cap_y[base]), 0);
    checkOutput("hwrst_first_d", 32'(cap_d[base]), 'hBEEF);
    checkOutput("hwrst_end_x",   32'(cap_x[base + 319]), 319);
    checkOutput("hwrst_end_y",   32'(cap_y[base + 319]), 0);
    checkOutput("hwrst_next_x",  32'(cap_x[base + 320]), 0);
    checkOutput("hwrst_next_y",  32'(cap_y[base + 320]), 1);

    $display("[TB] WR/RD collision");
    checkOutput("perr_before", 32'(protocol_err), 0);
    screenRS   = 1'b0;
    screenData = 16'h0000;
    screenWR   = 1'b0;
    screenRD   = 1'b0;
    @(negedge clk);
    screenWR   = 1'b1;
    screenRD   = 1'b1;
    idle(3);
    checkOutput("perr_set", 32'(protocol_err), 1);
    screenRESET = 1'b0;
    idle(3);
    screenRESET = 1'b1;
    idle(3);
    checkOutput("perr_after_hwrst", 32'(protocol_err), 1);
    rst_n = 1'b0;
    idle(1);
    checkOutput("perr_after_rst_n", 32'(protocol_err), 0);
    rst_n = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
